// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Pipeline sequencing controller for the 5-stage RV32 core.
//            Each cycle it decides stall (hold) and flush (bubble) controls
//            for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//            The hazard sources are data-memory wait states, multi-cycle
//            mul/div, taken branches/jumps and load-use. They are resolved
//            in that fixed priority order.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MD_TIMEOUT       : maximum MD_BUSY cycles before the mul/div is abandoned
//                      (legal 2..255)
// Ports
//   clk, rst         : core clock, asynchronous active-high reset
//   rs1_id, rs2_id   : source registers of the ID instruction
//   use_rs1_id/rs2_id: ID instruction really reads rs1 / rs2
//   rd_ex            : destination register of the EX instruction
//   mem_read_ex      : EX instruction is a load
//   branch_taken_ex  : EX branch/jump redirects the PC
//   md_start_ex      : EX instruction is a mul/div (pulse)
//   md_done          : mul/div result valid (pulse)
//   dmem_req_mem     : MEM instruction accesses data memory
//   dmem_ready       : data memory completes the access this cycle
//   stall_f/d/e/m    : hold PC, IF/ID, ID/EX, EX/MEM
//   flush_d/e/m/w    : bubble into IF/ID, ID/EX, EX/MEM, MEM/WB
//   md_timeout       : sticky flag, a mul/div exceeded MD_TIMEOUT
//   stall_cycles     : cycles with stall_f high (performance counter)
// Build option
//   HAZARD_CTRL_PERF_EN : when defined, stall_cycles is a saturating counter;
//                         otherwise it is tied to zero and has no flops.
// ============================================================================
module hazard_controller #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        use_rs1_id,
    input  logic        use_rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        mem_read_ex,
    input  logic        branch_taken_ex,
    input  logic        md_start_ex,
    input  logic        md_done,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m,
    output logic        flush_w,
    output logic        md_timeout,
    output logic [31:0] stall_cycles
);

    // Elaboration-time range check on the timeout parameter.
    if (MD_TIMEOUT < 2 || MD_TIMEOUT > 255) begin : g_md_timeout_range_err
        $error("hazard_controller: MD_TIMEOUT out of range 2..255");
    end

    // Counter value seen in the last MD_BUSY cycle allowed before abort.
    localparam logic [7:0] c_md_limit = 8'(MD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic       md_timeout_q, md_timeout_d;

    logic w_mem_wait;
    logic w_load_use;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_flush_d, w_flush_e, w_flush_m, w_flush_w;

    assign w_mem_wait = dmem_req_mem && !dmem_ready;

    // x0 is never a real dependency, so a load to x0 needs no bubble.
    assign w_load_use = mem_read_ex && (rd_ex != 5'd0) &&
                        ((use_rs1_id && (rs1_id == rd_ex)) ||
                         (use_rs2_id && (rs2_id == rd_ex)));

    // ------------------------------------------------------------------------
    // State register, mul/div watchdog counter and sticky timeout flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            md_cnt_q     <= 8'd0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode, highest-priority hazard first
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_stall_e    = 1'b0;
        w_stall_m    = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_flush_m    = 1'b0;
        w_flush_w    = 1'b0;

        if (w_mem_wait) begin
            // Freeze everything up to MEM; WB gets a bubble. The FSM and the
            // watchdog hold so a wait simply lengthens a mul/div stall.
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (state_q == ST_MD_BUSY) begin
            md_cnt_d = md_cnt_q + 8'd1;
            if (md_done) begin
                // Release in the done cycle so EX/MEM captures the result.
                state_d = ST_RUN;
            end else begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_stall_e = 1'b1;
                w_flush_m = 1'b1;
                if (md_cnt_q == c_md_limit) begin
                    state_d      = ST_RUN;
                    md_timeout_d = 1'b1;
                end
            end
        end else if (md_start_ex) begin
            // A result already valid in the start cycle needs no stall.
            if (!md_done) begin
                w_stall_f = 1'b1;
                w_stall_d = 1'b1;
                w_stall_e = 1'b1;
                w_flush_m = 1'b1;
                state_d   = ST_MD_BUSY;
                md_cnt_d  = 8'd0;
            end
        end else if (branch_taken_ex) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    // While reset is held the inputs may carry stale values from the rest of
    // the core; force all controls low so the pipeline sees a clean reset.
    assign stall_f    = w_stall_f & ~rst;
    assign stall_d    = w_stall_d & ~rst;
    assign stall_e    = w_stall_e & ~rst;
    assign stall_m    = w_stall_m & ~rst;
    assign flush_d    = w_flush_d & ~rst;
    assign flush_e    = w_flush_e & ~rst;
    assign flush_m    = w_flush_m & ~rst;
    assign flush_w    = w_flush_w & ~rst;
    assign md_timeout = md_timeout_q;

    // ------------------------------------------------------------------------
    // Optional stall performance counter
    // ------------------------------------------------------------------------
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
        end else if (stall_f && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage RV32 core. It decides stalls, bubbles and flushes for every pipeline register each cycle, based on four hazard sources: load-use hazards, taken branches/jumps, multi-cycle mul/div operations and data-memory wait states. Register-to-register RAW hazards are already resolved by forwarding, so this block stalls only where forwarding cannot help. It sits beside the forwarding logic in the core top level and drives the enable and clear inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- MD_TIMEOUT, 64: maximum number of MD_BUSY cycles before abort; legal range 2..255.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_id, rs2_id  in  5 each  source registers of the instruction in ID.
- use_rs1_id, use_rs2_id  in  1 each  the ID instruction actually reads rs1 / rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- mem_read_ex  in  1  the EX instruction is a load.
- branch_taken_ex  in  1  a branch/jump in EX redirects the PC.
- md_start_ex  in  1  the EX instruction is a mul/div; pulse, valid in RUN only.
- md_done  in  1  mul/div unit result is valid; single-cycle pulse.
- dmem_req_mem  in  1  the MEM instruction is accessing data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM.
- flush_d, flush_e, flush_m, flush_w  out  1 each  load a bubble into IF/ID, ID/EX, EX/MEM, MEM/WB.
- md_timeout  out  1  sticky error flag: a mul/div exceeded MD_TIMEOUT.
- stall_cycles  out  32  performance counter; see Configuration.

## Operation
- FSM states: RUN, MD_BUSY. Reset state: RUN.
- Outputs are combinational from the state and the inputs. Hazard sources are evaluated in fixed priority; the first one that fires wins, and lower-priority sources are ignored that cycle:
  1. Mem wait: dmem_req_mem && !dmem_ready, in any state. Assert stall_f, stall_d, stall_e, stall_m and flush_w; all other outputs are 0. The FSM state and md counter hold.
  2. MD_BUSY, no mem wait: assert stall_f, stall_d, stall_e and flush_m.
     - On md_done: exit to RUN. Stalls drop in that same cycle so EX/MEM captures the result.
  3. RUN with md_start_ex: assert stall_f, stall_d, stall_e and flush_m; next state MD_BUSY. If md_done is also high in this cycle, stay in RUN with no stall (single-cycle op).
  4. RUN with branch_taken_ex: assert flush_d and flush_e; no stalls.
  5. RUN with load-use: mem_read_ex && rd_ex != 0 && ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex)). Assert stall_f, stall_d and flush_e, giving exactly one bubble.
- A branch held in EX during a mem wait is not lost; it flushes on the first cycle the wait releases.
- md counter: 8 bits, cleared on entry to MD_BUSY, increments in each MD_BUSY cycle without a mem wait.
  - When it reaches MD_TIMEOUT-1 with no md_done: next state RUN, set md_timeout.
  - md_timeout is cleared only by rst.
- md_done received in RUN is ignored.
- stall_x and flush_x are never both high for the same register.

## Timing
- Reset values: state RUN, all stall and flush outputs 0, md_timeout 0, counter 0, stall_cycles 0.
- Reset asserted mid-MD_BUSY returns to RUN asynchronously. Outputs go to 0 immediately.
- Load-use costs exactly 1 cycle. A taken branch costs 2 bubbles with 0 stall cycles.
- A mul/div with md_done N cycles after start stalls the front end for N cycles; N = 0 gives no stall.
- Mem wait costs one stall cycle per cycle of dmem_ready low. It adds cycle-for-cycle to any MD_BUSY duration.

## Configuration
- HAZARD_CTRL_PERF_EN defined: stall_cycles increments on every cycle with stall_f = 1. It saturates at 32'hFFFF_FFFF and is cleared by rst.
- Not defined: stall_cycles is tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Load-use: lw x5 in EX, add using rs1=x5 in ID → stall_f = stall_d = flush_e = 1 for exactly 1 cycle, then all 0. Same stimulus with rd_ex = 0 → no stall.
- Taken branch with a load-use also present → flush_d = flush_e = 1, stall_f = 0 (branch wins).
- md_start_ex, then md_done 5 cycles later → stall_f/d/e and flush_m high for 5 cycles, RUN on the done cycle. With md_done in the same cycle as md_start_ex → no stall.
- dmem_ready low for 3 cycles during MD_BUSY → 3 cycles of stall_m = flush_w = 1 with the md counter frozen, then MD_BUSY resumes.
- MD_TIMEOUT = 4, md_done never asserted → return to RUN after 4 MD_BUSY cycles and md_timeout = 1. md_timeout stays 1 until rst.
- rst pulse mid-MD_BUSY → all outputs 0 immediately. With HAZARD_CTRL_PERF_EN defined, stall_cycles = 0 after reset and equals 7 after the 7-cycle stall sequence above.
